// File: rtl/systolic_ctrl_pkg.sv
// Shared types and skew-length helpers for the systolic array sequencer.
package systolic_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        COMPUTE,
        DONE
    } sysctrl_state_e;

    // Skewed input stream length for nv vectors.
    function automatic int unsigned l_in(input int unsigned nv, input int unsigned row,
                                         input int unsigned col);
        return nv + row + col - 2;
    endfunction

    // Skewed output stream length for nv vectors.
    function automatic int unsigned l_out(input int unsigned nv, input int unsigned col);
        return nv + col - 1;
    endfunction

endpackage

// File: rtl/systolic_ctrl.sv
// Weight-stationary systolic array sequencer: load weights, stream inputs, drain results.
// Optional busy-cycle counter enabled by SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int unsigned ROW     = 4,
    parameter int unsigned COL     = 4,
    parameter int unsigned MAX_VEC = 64,
    parameter int unsigned VW      = $clog2(MAX_VEC + 1),
    parameter int unsigned AW      = $clog2(MAX_VEC + ROW + COL),
    parameter int unsigned OUT_LAT = 2 * ROW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [VW-1:0]        num_vec_i,
    input  logic                 ext_en_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [ROW*COL-1:0]   ctrl_load_o,
    output logic [ROW*COL-1:0]   ctrl_sum_out_o,
    output logic                 wb_re_o,
    output logic [AW-1:0]        wb_addr_o,
    output logic                 ib_re_o,
    output logic [AW-1:0]        ib_addr_o,
    output logic                 ob_we_o,
    output logic [AW-1:0]        ob_addr_o
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_cycles_o
`endif
);

    // Wide enough for the largest COMPUTE count so cnt never wraps.
    localparam int unsigned CW = $clog2(OUT_LAT + MAX_VEC + COL + 1);
    localparam logic [VW-1:0] MAX_NV = VW'(MAX_VEC);

    sysctrl_state_e state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [VW-1:0]  nv_q, nv_d;
    logic           cnt_clr;
    logic           job_start;
    logic [VW-1:0]  nv_clamped;
    logic [CW-1:0]  l_in_c;
    logic [CW-1:0]  last_cnt;

    assign nv_clamped = (num_vec_i > MAX_NV) ? MAX_NV : num_vec_i;
    assign job_start  = (state_q == IDLE) && start_i && !ext_en_i;
    assign l_in_c     = CW'(l_in(32'(nv_q), ROW, COL));
    assign last_cnt   = CW'(OUT_LAT + l_out(32'(nv_q), COL) - 1);

    always_comb begin
        state_d = state_q;
        nv_d    = nv_q;
        cnt_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (job_start) begin
                    nv_d    = nv_clamped;
                    state_d = (nv_clamped == '0) ? DONE : LOAD_W;
                    cnt_clr = 1'b1;
                end
            end
            LOAD_W: begin
                if (cnt_q == CW'(ROW)) begin
                    state_d = COMPUTE;
                    cnt_clr = 1'b1;
                end
            end
            COMPUTE: begin
                if (cnt_q == last_cnt) begin
                    state_d = DONE;
                    cnt_clr = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    assign cnt_d = (cnt_clr || state_q == IDLE) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nv_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nv_q    <= nv_d;
        end
    end

    always_comb begin
        busy_o         = (state_q != IDLE);
        done_o         = 1'b0;
        ctrl_load_o    = '0;
        ctrl_sum_out_o = '0;
        wb_re_o        = 1'b0;
        wb_addr_o      = '0;
        ib_re_o        = 1'b0;
        ib_addr_o      = '0;
        ob_we_o        = 1'b0;
        ob_addr_o      = '0;
        unique case (state_q)
            LOAD_W: begin
                // Reverse order so weight row 0 settles in the top array row.
                if (cnt_q < CW'(ROW)) begin
                    wb_re_o   = 1'b1;
                    wb_addr_o = AW'(ROW - 1) - AW'(cnt_q);
                end
                if (cnt_q != '0) begin
                    ctrl_load_o = '1;
                end
            end
            COMPUTE: begin
                ctrl_sum_out_o = '1;
                if (cnt_q < l_in_c) begin
                    ib_re_o   = 1'b1;
                    ib_addr_o = AW'(cnt_q);
                end
                if (cnt_q >= CW'(OUT_LAT)) begin
                    ob_we_o   = 1'b1;
                    ob_addr_o = AW'(cnt_q - CW'(OUT_LAT));
                end
            end
            DONE: begin
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else if (job_start) begin
            perf_q <= '0;
        end else if (busy_o && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles_o = perf_q;
`else
    // Perf counter not built.
`endif

endmodule
